// File: rtl/mul_div_if.sv
// Handshake and data bundle between the control unit / register file and the
// multiply/divide unit. Port names follow the datapath signal names.
interface mul_div_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  // start is taken only while busy=0; done pulses one cycle when HI/LO were
  // just written by a finished operation; hi_we/lo_we apply when busy=0 and start=0.
  modport master (
    output start, op, rs_data, rt_data, hi_we, lo_we, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, rs_data, rt_data, hi_we, lo_we, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative 32x32 multiply / 32/32 divide with architectural HI/LO registers.
// Fixed 34-cycle latency: 32 shift/add or shift/subtract steps plus a sign-fix cycle.
module mul_div_unit (
    input  logic           clk,
    input  logic           rst_n,
    mul_div_if.slave       bus,
    output logic [1:0]     dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        is_div_q, is_div_d;
    logic        neg_q, neg_d;
    logic        rneg_q, rneg_d;
    logic [63:0] work_q, work_d;
    logic [31:0] opnd_q, opnd_d;
    logic [31:0] a_orig_q, a_orig_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;

    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    logic [32:0] mul_sum;
    logic [32:0] div_trial;
    logic [63:0] product;
    logic [31:0] quo, rem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= 5'd0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            work_q   <= 64'd0;
            opnd_q   <= 32'd0;
            a_orig_q <= 32'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            work_q   <= work_d;
            opnd_q   <= opnd_d;
            a_orig_q <= a_orig_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        work_d   = work_q;
        opnd_d   = opnd_q;
        a_orig_d = a_orig_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        // op[0]=1 selects the unsigned variants; 0x80000000 negates to itself,
        // which read as unsigned is exactly 2^31.
        a_neg = ~bus.op[0] & bus.rs_data[31];
        b_neg = ~bus.op[0] & bus.rt_data[31];
        a_mag = a_neg ? (32'd0 - bus.rs_data) : bus.rs_data;
        b_mag = b_neg ? (32'd0 - bus.rt_data) : bus.rt_data;

        // Multiply keeps {partial_product, multiplier} and shifts right;
        // divide keeps {remainder, quotient} and shifts left.
        mul_sum   = {1'b0, work_q[63:32]} + (work_q[0] ? {1'b0, opnd_q} : 33'd0);
        div_trial = work_q[63:31] - {1'b0, opnd_q};
        product   = neg_q ? (64'd0 - work_q) : work_q;
        quo       = work_q[31:0];
        rem       = work_q[63:32];

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d  = S_CALC;
                    cnt_d    = 5'd0;
                    is_div_d = bus.op[1];
                    neg_d    = a_neg ^ b_neg;
                    rneg_d   = a_neg;
                    a_orig_d = bus.rs_data;
                    opnd_d   = bus.op[1] ? b_mag : a_mag;
                    work_d   = {32'd0, (bus.op[1] ? a_mag : b_mag)};
                end else begin
                    if (bus.hi_we) hi_d = bus.wdata;
                    if (bus.lo_we) lo_d = bus.wdata;
                end
            end
            S_CALC: begin
                if (is_div_q) begin
                    if (!div_trial[32]) work_d = {div_trial[31:0], work_q[30:0], 1'b1};
                    else                work_d = {work_q[62:0], 1'b0};
                end else begin
                    work_d = {mul_sum, work_q[31:1]};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = S_FIX;
            end
            S_FIX: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                if (!is_div_q) begin
                    hi_d = product[63:32];
                    lo_d = product[31:0];
                end else if (opnd_q == 32'd0) begin
                    hi_d = a_orig_q;
                    lo_d = 32'hFFFF_FFFF;
                end else begin
                    hi_d = rneg_q ? (32'd0 - rem) : rem;
                    lo_d = neg_q  ? (32'd0 - quo) : quo;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.busy    = (state_q != S_IDLE);
    assign bus.done    = done_q;
    assign bus.hi      = hi_q;
    assign bus.lo      = lo_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed and random checks of mul_div_unit against an independent 64-bit model.
module tb_mul_div_unit;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;
  int         n_checks;
  int         n_errors;
  logic [63:0] exp_q[$];

  mul_div_if u_if ();

  mul_div_unit u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (u_if.slave),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // reference model: {HI, LO}
  function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb, q, r;
    longint unsigned ua, ub, uq, ur;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    res = 64'd0;
    case (o)
      OP_MULT:  res = 64'(sa * sb);
      OP_MULTU: res = 64'(ua * ub);
      OP_DIV: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else begin
          uq = ua / ub;
          ur = ua % ub;
          res = {ur[31:0], uq[31:0]};
        end
      end
    endcase
    return res;
  endfunction

  // scoreboard: every done pulse pops one expected {HI,LO}
  always @(negedge clk) begin
    if (rst_n === 1'b1 && u_if.done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        check("hilo_result", {u_if.hi, u_if.lo}, exp_q.pop_front());
      end
    end
  end

  // driver tasks; called at a negedge, return at the negedge of the done cycle
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int cycles;
    exp_q.push_back(ref_model(o, a, b));
    u_if.start   = 1'b1;
    u_if.op      = o;
    u_if.rs_data = a;
    u_if.rt_data = b;
    @(negedge clk);
    u_if.start   = 1'b0;
    u_if.rs_data = $urandom;
    u_if.rt_data = $urandom;
    cycles = 0;
    while (u_if.busy === 1'b1 && cycles < 40) begin
      cycles++;
      @(negedge clk);
    end
    check("busy_len", 64'(cycles), 64'd33);
    check("done_at_end", {63'd0, u_if.done}, 64'd1);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0: v = 32'd0;
      1: v = 32'h8000_0000;
      2: v = 32'hFFFF_FFFF;
      3: v = $urandom_range(0, 20);
      4: v = 32'd0 - 32'($urandom_range(1, 20));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    int cycles;
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    u_if.start = 1'b0; u_if.op = 2'b00; u_if.rs_data = 32'd0; u_if.rt_data = 32'd0;
    u_if.hi_we = 1'b0; u_if.lo_we = 1'b0; u_if.wdata = 32'd0;

    #12;
    check("reset_hi", {32'd0, u_if.hi}, 64'd0);
    check("reset_lo", {32'd0, u_if.lo}, 64'd0);
    check("reset_busy", {63'd0, u_if.busy}, 64'd0);
    check("reset_done", {63'd0, u_if.done}, 64'd0);
    check("reset_state", {62'd0, dbg_state}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(2);

    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(OP_MULT,  32'hFFFF_FFFD, 32'd5);
    run_op(OP_DIV,   32'hFFFF_FFF9, 32'd2);
    run_op(OP_DIVU,  32'd100, 32'd0);
    run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
    idle_cycles(1);
    check("hold_after_done_hi", {32'd0, u_if.hi}, 64'd0);
    check("hold_after_done_lo", {32'd0, u_if.lo}, 64'h8000_0000);

    // MULTU 6x7 with an ignored start at T+5 and a dropped MTHI at T+10
    exp_q.push_back(64'd42);
    u_if.start = 1'b1; u_if.op = OP_MULTU; u_if.rs_data = 32'd6; u_if.rt_data = 32'd7;
    @(negedge clk);
    u_if.start = 1'b0;
    cycles = 1;
    while (u_if.busy === 1'b1 && cycles < 41) begin
      u_if.start = (cycles == 5);
      if (cycles == 5) begin
        u_if.op = OP_DIVU; u_if.rs_data = 32'd9; u_if.rt_data = 32'd3;
      end
      u_if.hi_we = (cycles == 10);
      u_if.wdata = (cycles == 10) ? 32'h1234 : 32'd0;
      if (cycles == 20) check("hold_during_calc_lo", {32'd0, u_if.lo}, 64'h8000_0000);
      cycles++;
      @(negedge clk);
    end
    u_if.start = 1'b0; u_if.hi_we = 1'b0;
    check("busy_len_interfere", 64'(cycles - 1), 64'd33);
    check("done_interfere", {63'd0, u_if.done}, 64'd1);
    u_if.lo_we = 1'b1; u_if.wdata = 32'hABCD;
    @(negedge clk);
    u_if.lo_we = 1'b0;
    check("mtlo_lo", {32'd0, u_if.lo}, 64'hABCD);
    check("mtlo_hi_kept", {32'd0, u_if.hi}, 64'd0);
    check("mtlo_no_done", {63'd0, u_if.done}, 64'd0);
    check("mtlo_not_busy", {63'd0, u_if.busy}, 64'd0);
    u_if.hi_we = 1'b1; u_if.wdata = 32'h5A5A_0001;
    @(negedge clk);
    u_if.hi_we = 1'b0;
    check("mthi_hi", {32'd0, u_if.hi}, 64'h5A5A_0001);

    // abort MULT 0x10000 x 0x10000 with reset at T+20
    u_if.start = 1'b1; u_if.op = OP_MULT; u_if.rs_data = 32'h10000; u_if.rt_data = 32'h10000;
    @(negedge clk);
    u_if.start = 1'b0;
    idle_cycles(19);
    rst_n = 1'b0;
    #1;
    check("abort_hi", {32'd0, u_if.hi}, 64'd0);
    check("abort_lo", {32'd0, u_if.lo}, 64'd0);
    check("abort_busy", {63'd0, u_if.busy}, 64'd0);
    check("abort_done", {63'd0, u_if.done}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(40);
    run_op(OP_MULT, 32'h10000, 32'h10000);

    // random back-to-back ops, each started in the previous done cycle
    for (int i = 0; i < 1000; i++) begin
      run_op(2'($urandom_range(0, 3)), pick_operand(), pick_operand());
    end
    idle_cycles(3);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative multiply/divide unit for the MIPS datapath, sitting directly downstream of the register file. It consumes the two register read ports (rs and rt values) for MULT, MULTU, DIV and DIVU and produces the 64-bit result in the architectural HI/LO registers. HI/LO also accept MTHI/MTLO writes and are read back through the hi/lo outputs for MFHI/MFLO. Each operation is a fixed-latency 34-cycle shift/add (or shift/subtract) sequence with a busy/done handshake toward the control unit.

## Interface
- No parameters; the data width is fixed at 32.
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin the operation selected by op; sampled only while busy=0
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- rs_data  in  32  operand A (multiplicand or dividend), from read_data1
- rt_data  in  32  operand B (multiplier or divisor), from read_data2
- hi_we  in  1  MTHI: write wdata to HI
- lo_we  in  1  MTLO: write wdata to LO
- wdata  in  32  MTHI/MTLO data
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse, HI/LO just updated by an operation
- hi  out  32  HI register
- lo  out  32  LO register

## Operation
- FSM states:
  - IDLE: on start → CALC; operands latched; iteration counter = 0.
  - CALC: 32 iterations, one per cycle.
  - FIX: sign correction; HI/LO written.
  - IDLE: done=1 in the first IDLE cycle after FIX.
- Signed ops (MULT, DIV):
  - Operands are converted to 32-bit magnitudes at latch time.
  - A magnitude of 0x80000000 is represented exactly as unsigned 2^31.
  - The result sign flags are recorded at latch time.
- Multiply (CALC):
  - Shift-add over a 64-bit accumulator, LSB-first on the multiplier.
  - FIX: if the product is negative, the 64-bit two's complement is taken.
  - Result: {HI,LO} = product.
- Divide (CALC):
  - Restoring division: shift the remainder:quotient pair left by 1, trial-subtract the divisor magnitude, set the quotient bit when the result is non-negative.
  - FIX: quotient negated if sign(rs)≠sign(rt); remainder negated if rs<0.
  - Result: LO = quotient, HI = remainder.
- Divide-by-zero (rt_data=0, DIV or DIVU):
  - Full latency is still taken.
  - Result: LO=0xFFFFFFFF, HI=rs_data (original value, unsigned).
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0x00000000. This is natural truncation; no trap is raised.
- start while busy=1: ignored.
- No new operation is latched while the unit is busy.
- MTHI/MTLO:
  - hi_we/lo_we take effect only when busy=0 and start=0.
  - If start=1 in the same cycle, start wins and the write is dropped.
  - Writes while busy are dropped.
- hi/lo hold their value during CALC and FIX; no partial results are visible.
- Reset (asynchronous, any state):
  - State → IDLE; busy=0, done=0, hi=0, lo=0.
  - Any in-flight operation is aborted with no HI/LO update.

## Timing
- start is sampled high in cycle T (busy=0):
  - busy=1 in cycles T+1…T+33: 32 CALC cycles, then 1 FIX cycle.
  - HI/LO update on the rising edge that ends T+33.
  - Cycle T+34: done=1, busy=0, hi/lo show the new result.
  - A new start is accepted in T+34, giving back-to-back throughput of one operation per 34 cycles.
- MTHI/MTLO: hi/lo show wdata in the cycle after the write is sampled.
- done is asserted for exactly one cycle per completed operation, and never after an MTHI/MTLO write or an aborted operation.
- Operands are captured at start; changes to rs_data/rt_data during busy have no effect.

## Test plan
- Reset then MULTU 0xFFFFFFFF × 0xFFFFFFFF → after 34 cycles, done pulse, HI=0xFFFFFFFE, LO=0x00000001; busy high for exactly 33 cycles.
- MULT −3 (0xFFFFFFFD) × 5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1. DIV −7 ÷ 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 100 ÷ 0 → LO=0xFFFFFFFF, HI=0x00000064. DIV 0x80000000 ÷ 0xFFFFFFFF → LO=0x80000000, HI=0x00000000.
- MULTU 6×7 in progress:
  - Second start (DIVU 9÷3) at T+5 is ignored; result HI=0, LO=42.
  - hi_we with wdata=0x1234 at T+10 is dropped.
  - After done, MTLO 0xABCD → lo=0xABCD next cycle, with no done pulse.
- rst_n low at T+20 of MULT 0x10000×0x10000:
  - Immediately hi=lo=0, busy=0, and no done pulse follows.
  - Next start completes normally with HI=0x00000001, LO=0x00000000.
- Random signed/unsigned operands (≥1000 ops, back-to-back starts in the done cycle) against a 64-bit reference model.
